// File: rtl/thermostat_hvac_ctrl.sv
// HVAC relay controller: hysteresis start/stop thresholds and a short-cycle
// lockout between runs, driving the fan / AC / heat relay outputs.
`timescale 1ns/1ps

module thermostat_hvac_ctrl #(
  parameter int unsigned g_sc_delay_time = 12000000,
  parameter int unsigned g_hysteresis    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sys_on,
  input  logic [2:0] i_heat_cool,
  input  logic       i_force_fan,
  input  logic [7:0] i_target_temp,
  input  logic [7:0] i_cur_temp,
  input  logic       i_temp_valid,
  output logic       o_green_fan,
  output logic       o_yellow_ac,
  output logic       o_white_heat,
  output logic       o_sc_lockout,
  output logic       o_temp_seen
);

  localparam int unsigned CNT_W = (g_sc_delay_time > 1) ? $clog2(g_sc_delay_time) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(g_sc_delay_time - 1);
  localparam logic [8:0] HYST9 = 9'(g_hysteresis);

  typedef enum logic [1:0] {
    ST_LOCKOUT = 2'd0,
    ST_IDLE    = 2'd1,
    ST_HEAT    = 2'd2,
    ST_COOL    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_temp;
  logic             r_temp_seen;
  logic             r_force;

  logic       heat_en;
  logic       cool_en;
  logic [8:0] temp9;
  logic [8:0] tgt9;
  logic       heat_start;
  logic       heat_stop;
  logic       cool_start;
  logic       cool_stop;

  // Auto mode (100) enables both directions; non-one-hot codes enable neither.
  assign heat_en = i_sys_on & ((i_heat_cool == 3'b001) | (i_heat_cool == 3'b100));
  assign cool_en = i_sys_on & ((i_heat_cool == 3'b010) | (i_heat_cool == 3'b100));

  // Zero-extended to 9 bits so adding the hysteresis never wraps.
  assign temp9      = {1'b0, r_temp};
  assign tgt9       = {1'b0, i_target_temp};
  assign heat_start = (temp9 + HYST9) <= tgt9;
  assign heat_stop  = temp9 >= tgt9;
  assign cool_start = temp9 >= (tgt9 + HYST9);
  assign cool_stop  = temp9 <= tgt9;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_LOCKOUT;
      r_count     <= CNT_LOAD;
      r_temp      <= '0;
      r_temp_seen <= 1'b0;
      r_force     <= 1'b0;
    end else begin
      r_force <= i_force_fan & i_sys_on;
      if (i_temp_valid) begin
        r_temp      <= i_cur_temp;
        r_temp_seen <= 1'b1;
      end
      case (r_state)
        ST_LOCKOUT: begin
          if (r_count == '0) r_state <= ST_IDLE;
          else               r_count <= r_count - CNT_W'(1);
        end
        ST_IDLE: begin
          // Heat wins when both thresholds hold (only possible with zero hysteresis).
          if (r_temp_seen && heat_en && heat_start)      r_state <= ST_HEAT;
          else if (r_temp_seen && cool_en && cool_start) r_state <= ST_COOL;
        end
        ST_HEAT: begin
          if (heat_stop || !heat_en) begin
            r_state <= ST_LOCKOUT;
            r_count <= CNT_LOAD;
          end
        end
        ST_COOL: begin
          if (cool_stop || !cool_en) begin
            r_state <= ST_LOCKOUT;
            r_count <= CNT_LOAD;
          end
        end
        default: begin
          r_state <= ST_LOCKOUT;
          r_count <= CNT_LOAD;
        end
      endcase
    end
  end

  assign o_white_heat = (r_state == ST_HEAT);
  assign o_yellow_ac  = (r_state == ST_COOL);
  assign o_green_fan  = (r_state == ST_HEAT) | (r_state == ST_COOL) | r_force;
  assign o_sc_lockout = (r_state == ST_LOCKOUT);
  assign o_temp_seen  = r_temp_seen;

endmodule
